// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, default timing knobs and
// counter sizing helpers. Also imported by the CPU and DMA blocks.
package bus_arbiter_pkg;

  // Bus ownership phases seen by the arbiter (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // CPU owns the bus
    ST_DRAIN   = 2'd1,  // DMA requested, waiting for the CPU access to finish
    ST_GRANT   = 2'd2,  // DMA owns the bus
    ST_RELEASE = 2'd3   // one-cycle handback to the CPU
  } bus_state_e;

  // Default grant length that counts as an overlong DMA hold.
  localparam int unsigned DEF_MAX_HOLD    = 32;
  // Default number of CPU-owned cycles forced between two DMA grants.
  localparam int unsigned DEF_MIN_CPU_GAP = 2;

  // Hold counter geometry: 8 bits, saturating.
  localparam int unsigned    HOLD_W   = 8;
  localparam int unsigned    HOLD_MAX = 255;
  localparam logic [HOLD_W-1:0] HOLD_SAT = 8'hFF;

  // Gap counter width: clog2(gap+1), but never narrower than one bit so a
  // zero gap still yields a legal (always-zero) counter.
  function automatic int unsigned gap_width(input int unsigned gap);
    if (gap == 0) return 1;
    return $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// DMA/CPU bus arbiter. The CPU owns the bus by default; a DMA request first
// drains any in-flight CPU access, then holds the bus until BR drops. After
// each handback the CPU is guaranteed MIN_CPU_GAP cycles of ownership.
// Overlong grants raise a sticky hold_timeout flag.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD    = DEF_MAX_HOLD,
  parameter int unsigned MIN_CPU_GAP = DEF_MIN_CPU_GAP
) (
  input  logic CLK,
  input  logic reset,
  input  logic BR,
  input  logic cpu_mem_busy,
  input  logic cpu_mem_req,
  output logic BG,
  output logic cpu_stall,
  output logic dma_done,
  output logic hold_timeout
);

  localparam int unsigned GAP_W = gap_width(MIN_CPU_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_CPU_GAP);
  // A limit above the saturation point can never be reached; all-ones on
  // HOLD_W+1 bits is outside the reachable range of hold_cnt+1.
  localparam logic [HOLD_W:0] HOLD_LIMIT =
    (MAX_HOLD > HOLD_MAX) ? '1 : (HOLD_W+1)'(MAX_HOLD);
  localparam logic [HOLD_W:0] HOLD_ONE = {{HOLD_W{1'b0}}, 1'b1};

  bus_state_e        state, state_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W:0]   hold_inc;
  logic              gap_open;
  logic              enter_grant;
  logic              hold_hit;

  // State register; reset wins over any pending transition.
  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. DRAIN waits indefinitely for the CPU access to finish;
  // GRANT is never preempted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (BR && gap_open) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!BR)                state_nxt = ST_IDLE;
        else if (!cpu_mem_busy) state_nxt = ST_GRANT;
      end
      ST_GRANT:   if (!BR) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs and counter control terms.
  always_comb begin
    cpu_stall   = cpu_mem_req && (state != ST_IDLE);
    gap_open    = (gap_cnt == '0);
    enter_grant = (state == ST_DRAIN) && (state_nxt == ST_GRANT);
    hold_inc    = {1'b0, hold_cnt} + HOLD_ONE;
    // The flag is raised on the edge at which the counter would reach
    // MAX_HOLD, i.e. after MAX_HOLD grant-cycle edges.
    hold_hit    = (state == ST_GRANT) && (hold_inc == HOLD_LIMIT);
  end

  // Registered outputs follow the state being entered, so BG and dma_done
  // line up exactly with GRANT and RELEASE. Reset clears them with no pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      BG           <= 1'b0;
      dma_done     <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      BG           <= (state_nxt == ST_GRANT);
      dma_done     <= (state_nxt == ST_RELEASE);
      hold_timeout <= hold_timeout | hold_hit;
    end
  end

  // Gap counter: armed on the RELEASE->IDLE handback, then counts down in
  // IDLE; BR is ignored until it reaches zero.
  always_ff @(posedge CLK) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == ST_RELEASE) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == ST_IDLE) && !gap_open) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Hold counter: cleared on entry to GRANT, counts grant cycles, saturates.
  always_ff @(posedge CLK) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (enter_grant) begin
      hold_cnt <= '0;
    end else if ((state == ST_GRANT) && (hold_cnt != HOLD_SAT)) begin
      hold_cnt <= hold_inc[HOLD_W-1:0];
    end
  end

  // Grant output must mirror the GRANT state, and a handback is never
  // coincident with a grant.
  a_bg_state: assert property (@(posedge CLK) disable iff (reset)
    BG == (state == ST_GRANT));
  a_done_excl: assert property (@(posedge CLK) disable iff (reset)
    !(BG && dma_done));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a directed vector table, hand sequences for hold
// timeout, reset-in-grant and zero-gap handback, then randomized traffic
// checked against an ownership-level reference model.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 32;
  localparam int MIN_GAP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, br, busy, req;
  logic bg, stall, done, tout;
  logic rst0, br0, busy0, req0;
  logic bg0, stall0, done0, tout0;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .MIN_CPU_GAP(MIN_GAP)) u_dut (
    .CLK(clk), .reset(rst), .BR(br), .cpu_mem_busy(busy), .cpu_mem_req(req),
    .BG(bg), .cpu_stall(stall), .dma_done(done), .hold_timeout(tout)
  );

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .MIN_CPU_GAP(0)) u_gap0 (
    .CLK(clk), .reset(rst0), .BR(br0), .cpu_mem_busy(busy0), .cpu_mem_req(req0),
    .BG(bg0), .cpu_stall(stall0), .dma_done(done0), .hold_timeout(tout0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, plus elapsed-cycle bookkeeping.
  bit m_dma, m_drain, m_hand, m_to;
  int m_quiet;   // CPU-owned cycles still protected after a handback
  int m_glen;    // grant cycles elapsed in the current grant

  task automatic model_step(input logic r, input logic b, input logic bz);
    if (r) begin
      m_dma = 0; m_drain = 0; m_hand = 0; m_to = 0; m_quiet = 0; m_glen = 0;
    end else if (m_hand) begin
      m_hand  = 0;
      m_quiet = MIN_GAP;
    end else if (m_dma) begin
      m_glen++;
      if (m_glen >= MAX_HOLD) m_to = 1;
      if (!b) begin m_dma = 0; m_hand = 1; end
    end else if (m_drain) begin
      if (!b) m_drain = 0;
      else if (!bz) begin m_drain = 0; m_dma = 1; m_glen = 0; end
    end else begin
      if (m_quiet > 0) m_quiet--;
      else if (b) m_drain = 1;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".BG"},   bg,    m_dma);
    chk({tag, ".done"}, done,  m_hand);
    chk({tag, ".stall"}, stall, req && (m_dma || m_drain || m_hand));
    chk({tag, ".tout"}, tout,  m_to);
  endtask

  // One clock: main DUT inputs already driven; model steps on the same edge.
  task automatic tick();
    @(posedge clk);
    model_step(rst, br, busy);
    #1;
  endtask

  task automatic apply(input logic r, input logic b, input logic bz, input logic q);
    rst = r; br = b; busy = bz; req = q;
    tick();
  endtask

  task automatic apply0(input logic r, input logic b, input logic bz, input logic q);
    rst0 = r; br0 = b; busy0 = bz; req0 = q;
    tick();
  endtask

  typedef struct {
    logic rst, br, busy, req;
    logic bg, done, stall, to;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic bz, input logic q,
                              input logic ebg, input logic ed, input logic es, input logic et);
    vec_t v;
    v.rst = r; v.br = b; v.busy = bz; v.req = q;
    v.bg = ebg; v.done = ed; v.stall = es; v.to = et;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    bit   rate_fast;

    rst = 1; br = 0; busy = 0; req = 0;
    rst0 = 1; br0 = 0; busy0 = 0; req0 = 0;
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);

    //            rst br bsy req   BG done stall to
    tbl.push_back(mk(1, 1, 0, 1,   0, 0, 0, 0));  // reset holds IDLE
    tbl.push_back(mk(0, 1, 0, 1,   0, 0, 1, 0));  // IDLE->DRAIN
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0, 0));  // DRAIN->GRANT
    tbl.push_back(mk(0, 1, 0, 1,   1, 0, 1, 0));  // hold grant
    tbl.push_back(mk(0, 0, 0, 1,   0, 1, 1, 0));  // GRANT->RELEASE
    tbl.push_back(mk(0, 0, 0, 1,   0, 0, 0, 0));  // RELEASE->IDLE, gap armed
    tbl.push_back(mk(0, 1, 0, 1,   0, 0, 0, 0));  // gap 2: BR ignored
    tbl.push_back(mk(0, 1, 0, 1,   0, 0, 0, 0));  // gap 1: BR ignored
    tbl.push_back(mk(0, 1, 1, 1,   0, 0, 1, 0));  // 3rd IDLE cycle -> DRAIN
    tbl.push_back(mk(0, 1, 1, 1,   0, 0, 1, 0));  // busy: stay DRAIN
    tbl.push_back(mk(0, 0, 1, 1,   0, 0, 0, 0));  // withdrawn -> IDLE, no done
    tbl.push_back(mk(0, 1, 1, 1,   0, 0, 1, 0));  // re-request -> DRAIN
    tbl.push_back(mk(0, 1, 0, 1,   1, 0, 1, 0));  // busy drops -> GRANT
    tbl.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0));  // RELEASE
    tbl.push_back(mk(0, 0, 0, 1,   0, 0, 0, 0));  // back to IDLE

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].br, tbl[i].busy, tbl[i].req);
      chk($sformatf("vec%0d.BG", i),    bg,    tbl[i].bg);
      chk($sformatf("vec%0d.done", i),  done,  tbl[i].done);
      chk($sformatf("vec%0d.stall", i), stall, tbl[i].stall);
      chk($sformatf("vec%0d.tout", i),  tout,  tbl[i].to);
      check_model($sformatf("vec%0d.m", i));
    end

    // Long hold: flag after MAX_HOLD grant edges, sticky until reset.
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    chk("hold.enter_bg", bg, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      apply(0, 1, 0, 0);
      if (k == MAX_HOLD - 1) chk("hold.before_limit", tout, 1'b0);
      if (k == MAX_HOLD)     chk("hold.at_limit", tout, 1'b1);
      check_model($sformatf("hold%0d", k));
    end
    apply(0, 0, 0, 0);
    chk("hold.release_done", done, 1'b1);
    chk("hold.release_tout", tout, 1'b1);
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 0);
    chk("hold.sticky_idle", tout, 1'b1);
    apply(1, 0, 0, 0);
    chk("hold.reset_clears", tout, 1'b0);

    // Reset in the 5th grant cycle: BG drops, no handback pulse.
    apply(0, 1, 0, 1);
    apply(0, 1, 0, 1);
    for (int k = 0; k < 4; k++) apply(0, 1, 0, 1);
    chk("rstgrant.bg_before", bg, 1'b1);
    apply(1, 1, 0, 1);
    chk("rstgrant.bg",    bg,    1'b0);
    chk("rstgrant.done",  done,  1'b0);
    chk("rstgrant.stall", stall, 1'b0);
    chk("rstgrant.tout",  tout,  1'b0);
    apply(0, 1, 0, 1);
    chk("rstgrant.rereq_stall", stall, 1'b1);
    chk("rstgrant.rereq_done",  done,  1'b0);
    check_model("rstgrant.m");

    // Zero gap: DRAIN may be entered on the first IDLE cycle after RELEASE.
    apply0(1, 0, 0, 0);
    apply0(0, 1, 0, 1);
    apply0(0, 1, 0, 1);
    chk("gap0.bg", bg0, 1'b1);
    apply0(0, 0, 0, 1);
    chk("gap0.done", done0, 1'b1);
    apply0(0, 1, 0, 1);
    chk("gap0.idle_stall", stall0, 1'b0);
    apply0(0, 1, 0, 1);
    chk("gap0.drain_stall", stall0, 1'b1);
    chk("gap0.drain_bg", bg0, 1'b0);
    apply0(0, 1, 0, 1);
    chk("gap0.regrant_bg", bg0, 1'b1);

    // Randomized traffic against the model; BR burst length alternates
    // between short and long so both gap and timeout paths are exercised.
    rate_fast = 1;
    for (int c = 0; c < 3000; c++) begin
      logic r, b;
      if (c % 500 == 0) rate_fast = ~rate_fast;
      r = ($urandom_range(0, 299) == 0);
      b = br;
      if (rate_fast ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0)) b = ~b;
      apply(r, b, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
